// File: rtl/mux_32_arbiter.sv
// mux_32_bit_2_1: 32-bit 2:1 mux. in1 is selected when sel=0, in2 when sel=1.
//   in1, in2 : 32-bit data inputs
//   sel      : select
//   out      : selected word
module mux_32_bit_2_1 (
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic        sel,
  output logic [31:0] out
);

  assign out = sel ? in2 : in1;

endmodule

// mux_32_arbiter: round-robin arbiter that drives the shared 32-bit 2:1 mux,
// acknowledges the winning requester and captures the selected word into a
// one-entry output register with a valid/ready handshake.
//   clk, reset            : clock, synchronous active-high reset
//   req0/req1, data0/data1: requests and their words (held until granted)
//   gnt0/gnt1             : combinational acknowledge, high in the capture cycle
//   out_data/out_src      : captured word and the requester that supplied it
//   out_valid/out_ready   : output handshake
//   gnt_cnt0/gnt_cnt1     : wrapping per-requester grant counters
module mux_32_arbiter #(
  parameter int unsigned WIDTH = 32,  // fixed by the 32-bit mux instance
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             out_src,
  input  logic             out_ready,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             last;
  logic             load;
  logic             any_req;
  logic             winner;
  logic             capture;
  logic [WIDTH-1:0] mux_out;

  // Shared datapath mux, steered by the arbitration winner.
  mux_32_bit_2_1 u_mux (
    .in1 (data0),
    .in2 (data1),
    .sel (winner),
    .out (mux_out)
  );

  assign out_valid = (state == FULL);

  // Arbitration, grants and next state; grants never depend on data.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    winner    = 1'b0;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    any_req   = req0 | req1;
    capture   = 1'b0;

    load = !reset && ((state == EMPTY) || out_ready);

    // Under contention the requester that did not win last time goes next.
    if (req0 && req1) begin
      winner = ~last;
    end else if (req1) begin
      winner = 1'b1;
    end

    capture = load && any_req;
    gnt0    = load && !winner && req0;
    gnt1    = load &&  winner && req1;

    case (state)
      EMPTY: if (capture) state_nxt = FULL;
      FULL:  if (load && !any_req) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // State, output register, round-robin pointer and grant counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= EMPTY;
      out_data <= '0;
      out_src  <= 1'b0;
      last     <= 1'b1;
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        out_data <= mux_out;
        out_src  <= winner;
        last     <= winner;
        if (winner) begin
          gnt_cnt1 <= gnt_cnt1 + CNT_W'(1);
        end else begin
          gnt_cnt0 <= gnt_cnt0 + CNT_W'(1);
        end
      end
    end
  end

endmodule
